sample_dac_spi_tx: RTL and testbench

- Output-side counterpart to the resonator stimulus path: takes filter output samples, qualified by the sample-rate enable strobe, and serialises them to an external SPI DAC.
- Converts each signed two's-complement sample to offset binary and shifts it out MSB first in SPI mode 0.
- Holds one pending sample so a new sample can arrive while a frame is in flight, and flags overruns.

---
 rtl/sample_dac_spi_tx.sv | 150 +++++++++++++++
 tb/tb_sample_dac_spi_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_dac_spi_tx.sv
// Serialises enable-qualified signed samples to an SPI DAC (mode 0, MSB first) as offset binary.
// One pending sample is buffered while a frame is in flight; overwriting it pulses overrun.
module sample_dac_spi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SCLK_DIV   = 4,
  parameter int CS_IDLE    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] d,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic                  overrun
);

  // state  | meaning
  // IDLE   | cs_n high, waiting for a pending sample
  // SHIFT  | cs_n low, clocking out DATA_WIDTH bits
  // GAP    | cs_n high for CS_IDLE clocks before the next frame may start

  localparam int MSB   = DATA_WIDTH - 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int DIV_W = $clog2(2 * SCLK_DIV);
  localparam int GAP_W = $clog2(CS_IDLE + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_IDLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] hold, hold_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  pending, pending_nxt;
  logic [DIV_W-1:0]      div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
  logic                  sclk_nxt, mosi_nxt, cs_n_nxt, busy_nxt, overrun_nxt;
  logic                  start;

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    shreg_nxt   = shreg;
    pending_nxt = pending;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sclk_nxt    = sclk;
    mosi_nxt    = mosi;
    cs_n_nxt    = cs_n;
    busy_nxt    = busy;
    overrun_nxt = 1'b0;
    start       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pending) start = 1'b1;
      end
      ST_SHIFT: begin
        div_cnt_nxt = div_cnt + 1'b1;
        if (div_cnt == DIV_RISE) sclk_nxt = 1'b1;
        if (div_cnt == DIV_FALL) begin
          sclk_nxt    = 1'b0;
          div_cnt_nxt = '0;
          if (bit_cnt == LAST_BIT) begin
            cs_n_nxt    = 1'b1;
            mosi_nxt    = 1'b0;
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = ST_GAP;
          end else begin
            // next bit goes out on the sclk falling edge
            shreg_nxt   = {shreg[MSB-1:0], 1'b0};
            mosi_nxt    = shreg[MSB-1];
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          if (pending) start = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (start) begin
      shreg_nxt   = hold;
      mosi_nxt    = hold[MSB];
      cs_n_nxt    = 1'b0;
      busy_nxt    = 1'b1;
      div_cnt_nxt = '0;
      bit_cnt_nxt = '0;
      state_nxt   = ST_SHIFT;
    end

    // a sample consumed on this edge frees the slot, so a simultaneous capture is not an overrun
    if (enable) begin
      hold_nxt    = {~d[MSB], d[MSB-1:0]};
      pending_nxt = 1'b1;
      overrun_nxt = pending && !start;
    end else if (start) begin
      pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hold    <= '0;
      shreg   <= '0;
      pending <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      shreg   <= shreg_nxt;
      pending <= pending_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      cs_n    <= cs_n_nxt;
      busy    <= busy_nxt;
      overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_sample_dac_spi_tx.sv
// Scoreboard bench for sample_dac_spi_tx: expected DAC words queued at enable,
// compared when the SPI monitor sees a complete frame.
module tb_sample_dac_spi_tx;

  logic        tb_local_clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] d = '0;
  logic        sclk, mosi, cs_n, busy, overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb[$];

  // monitor state
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  logic        in_frame = 1'b0, have_prev_end = 1'b0;
  logic [15:0] shreg_m = '0;
  int          nbits = 0, low_cnt = 0, gap_cnt = 0, last_gap = -1;
  int          mosi_viol = 0, sclk_viol = 0, frames = 0, ovr_cnt = 0;

  always #5 tb_local_clock = ~tb_local_clock;

  sample_dac_spi_tx #(.DATA_WIDTH(16), .SCLK_DIV(4), .CS_IDLE(2)) dut (
    .clk(tb_local_clock), .reset(reset), .enable(enable), .d(d),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge tb_local_clock) begin
    if (reset) begin
      in_frame = 1'b0;
      nbits = 0;
      have_prev_end = 1'b0;
      sb.delete();
      prev_cs = 1'b1;
      prev_sclk = 1'b0;
      prev_mosi = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (prev_cs && !cs_n) begin
        in_frame = 1'b1;
        nbits = 0;
        low_cnt = 0;
        shreg_m = '0;
        if (have_prev_end) last_gap = gap_cnt;
      end
      if (!cs_n) begin
        low_cnt++;
        if (!prev_sclk && sclk) begin
          shreg_m = {shreg_m[14:0], mosi};
          nbits++;
        end
        if (prev_sclk && sclk && (mosi !== prev_mosi)) mosi_viol++;
      end else if (sclk) begin
        sclk_viol++;
      end
      if (!prev_cs && cs_n && in_frame) begin
        in_frame = 1'b0;
        frames++;
        check("frame_bits", nbits, 16);
        check("cs_low_clks", low_cnt, 128);
        check("mosi_stable", mosi_viol, 0);
        check("sclk_idle_low", sclk_viol, 0);
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) check("frame_data", shreg_m, sb.pop_front());
        mosi_viol = 0;
        sclk_viol = 0;
        have_prev_end = 1'b1;
        gap_cnt = 0;
      end
      if (cs_n) gap_cnt++;
      prev_cs = cs_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge tb_local_clock);
      #1;
    end
  endtask

  // drive one enable; replace=1 means the still-unsent pending sample is overwritten
  task automatic send(input logic [15:0] v, input logic [15:0] exp, input logic replace);
    d = v;
    enable = 1'b1;
    if (replace && sb.size() > 0) sb[sb.size()-1] = exp;
    else sb.push_back(exp);
    @(posedge tb_local_clock);
    #1;
    enable = 1'b0;
    check("overrun_at_enable", overrun, replace);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!busy && cs_n && sb.size() == 0) break;
      cycles(1);
    end
    check("idle_busy", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic quiet(input string tag, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      cycles(1);
      if (!cs_n || busy || sclk) act++;
    end
    check(tag, act, 0);
  endtask

  initial begin
    int f0, o0, rises;
    logic ps;

    // 1: reset with enable pulsing
    for (int i = 0; i < 5; i++) begin
      enable = i[0];
      d = 16'($urandom);
      @(posedge tb_local_clock);
      #1;
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
    end
    enable = 1'b0;
    reset = 1'b0;
    quiet("no_frame_after_reset", 200);

    // 2: single frame with latency and tail timing
    f0 = frames;
    send(16'h1234, 16'h9234, 1'b0);
    check("cs_before", cs_n, 1);
    cycles(1);
    check("cs_latency", cs_n, 0);
    check("busy_start", busy, 1);
    cycles(3);
    check("sclk_low_phase", sclk, 0);
    cycles(1);
    check("first_rise", sclk, 1);
    for (int i = 0; i < 300; i++) begin
      if (cs_n) break;
      cycles(1);
    end
    check("cs_rise", cs_n, 1);
    check("busy_gap0", busy, 1);
    cycles(1);
    check("busy_gap1", busy, 1);
    cycles(1);
    check("busy_end", busy, 0);
    wait_idle();
    check("frames_t2", frames - f0, 1);

    // 3: conversion extremes
    f0 = frames;
    send(16'h8000, 16'h0000, 1'b0); wait_idle();
    send(16'h7FFF, 16'hFFFF, 1'b0); wait_idle();
    send(16'h0000, 16'h8000, 1'b0); wait_idle();
    send(16'hFFFF, 16'h7FFF, 1'b0); wait_idle();
    check("frames_t3", frames - f0, 4);

    // 4: back-to-back frames
    f0 = frames;
    o0 = ovr_cnt;
    send(16'h0100, 16'h8100, 1'b0);
    cycles(9);
    send(16'h0200, 16'h8200, 1'b0);
    wait_idle();
    check("frames_t4", frames - f0, 2);
    check("gap_clks", last_gap, 2);
    check("no_overrun_t4", ovr_cnt - o0, 0);

    // 5: overrun, B dropped in favour of C
    f0 = frames;
    o0 = ovr_cnt;
    send(16'h1111, 16'h9111, 1'b0);
    cycles(19);
    send(16'h2222, 16'hA222, 1'b0);
    cycles(19);
    send(16'h3333, 16'hB333, 1'b1);
    wait_idle();
    check("frames_t5", frames - f0, 2);
    check("overrun_once", ovr_cnt - o0, 1);

    // 6: reset at the 7th sclk rise aborts the frame
    f0 = frames;
    send(16'h5555, 16'hD555, 1'b0);
    rises = 0;
    ps = sclk;
    for (int i = 0; i < 2000 && rises < 7; i++) begin
      @(negedge tb_local_clock);
      if (!ps && sclk) rises++;
      ps = sclk;
    end
    check("rises_reached", rises, 7);
    reset = 1'b1;
    cycles(1);
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    cycles(2);
    reset = 1'b0;
    quiet("no_frame_after_abort", 300);
    check("frames_aborted", frames - f0, 0);
    send(16'h7FFF, 16'hFFFF, 1'b0);
    wait_idle();
    check("frames_t6", frames - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
